seq_scan_arbiter: RTL and testbench

- Round-robin scheduler that shares one three-ones Mealy sequence detector among N_CH serial bit-stream requesters.
- Grants one channel at a time for a frame of programmable length and steers that channel's bits onto the detector input.
- Counts detector hits over the frame and reports the result on a one-cycle done strobe.
- Between frames it drives a 0 into the detector; the detector has no reset, and a 0 input returns it to its idle state.

---
 rtl/seq_scan_arbiter.sv | 146 ++++++++++++++
 tb/tb_seq_scan_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin scheduler that time-shares one external
// three-ones Mealy detector among N_CH serial bit-stream requesters.
// One channel is granted per frame. Its bits are steered onto det_x, and
// det_y hits are counted. The result is reported on a one-cycle done strobe.
module seq_scan_arbiter #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*LEN_W-1:0] frame_len,
    input  logic [N_CH-1:0]       ch_bit,
    output logic [N_CH-1:0]       gnt,
    output logic                  det_x,
    input  logic                  det_y,
    output logic                  busy,
    output logic                  done,
    output logic [CH_W-1:0]       done_ch,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic                  aborted
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t           state, state_n;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  cur_ch;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] bit_cnt;

    logic             win_vld;
    logic [CH_W-1:0]  win_ch;
    logic [LEN_W-1:0] win_len;

    logic             cur_req;
    logic             cur_bit;
    logic             last_bit;

    assign cur_req  = req[cur_ch];
    assign cur_bit  = ch_bit[cur_ch];
    assign last_bit = (bit_cnt == cur_len - 1'b1);

    // Round-robin search starting one past the last winner, with wrap-around.
    always_comb begin
        int idx;
        logic [CH_W-1:0] cand;
        win_vld = 1'b0;
        win_ch  = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx  = (int'(rr_ptr) + i) % N_CH;
            cand = CH_W'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_ch  = cand;
            end
        end
        win_len = frame_len[win_ch*LEN_W +: LEN_W];
    end

    // Next-state and state-decoded outputs. det_x is forced low outside live
    // SCAN bits so the detector is flushed between frames.
    always_comb begin
        state_n = state;
        det_x   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld)
                    state_n = (win_len != '0) ? SCAN : REPORT;
            end
            SCAN: begin
                busy  = 1'b1;
                det_x = cur_req & cur_bit;
                if (!cur_req || last_bit)
                    state_n = REPORT;
            end
            REPORT: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, frame latch, grant and hit counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            hit_cnt <= '0;
            aborted <= 1'b0;
            done_ch <= '0;
            rr_ptr  <= CH_W'(N_CH - 1);
            cur_ch  <= '0;
            cur_len <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cur_ch  <= win_ch;
                        cur_len <= win_len;
                        rr_ptr  <= win_ch;
                        done_ch <= win_ch;
                        hit_cnt <= '0;
                        aborted <= 1'b0;
                        bit_cnt <= '0;
                        // A zero-length frame skips SCAN and is never granted.
                        if (win_len != '0)
                            gnt <= {{(N_CH-1){1'b0}}, 1'b1} << win_ch;
                        else
                            gnt <= '0;
                    end
                end
                SCAN: begin
                    if (!cur_req) begin
                        // Requester withdrew: this bit and det_y are discarded.
                        aborted <= 1'b1;
                        gnt     <= '0;
                    end else begin
                        if (det_y && (hit_cnt != {CNT_W{1'b1}}))
                            hit_cnt <= hit_cnt + 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit)
                            gnt <= '0;
                    end
                end
                REPORT: begin
                    gnt <= '0;
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter. It models the shared three-ones detector
// externally. Expected done reports go into a queue, and a negedge monitor
// pops them and compares.
module tb_seq_scan_arbiter;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int LEN_W = 8;
    localparam int CNT_W = 2;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH-1:0]       req;
    logic [N_CH*LEN_W-1:0] frame_len;
    logic [N_CH-1:0]       ch_bit;
    logic [N_CH-1:0]       gnt;
    logic                  det_x;
    logic                  det_y;
    logic                  busy;
    logic                  done;
    logic [CH_W-1:0]       done_ch;
    logic [CNT_W-1:0]      hit_cnt;
    logic                  aborted;

    seq_scan_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .frame_len(frame_len), .ch_bit(ch_bit),
        .gnt(gnt), .det_x(det_x), .det_y(det_y), .busy(busy), .done(done),
        .done_ch(done_ch), .hit_cnt(hit_cnt), .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-ones Mealy detector: y on the 4th and later consecutive 1s.
    logic [1:0] dcnt = 2'd0;
    always @(posedge clk) dcnt <= det_x ? ((dcnt == 2'd3) ? 2'd3 : dcnt + 2'd1) : 2'd0;
    assign det_y = det_x && (dcnt == 2'd3);

    typedef struct {
        int ch;
        int cnt;
        bit ab;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done done_ch=%0d expected=none @%0t", done_ch, $time);
            end else begin
                mon_e = q.pop_front();
                chk("done_ch", done_ch, mon_e.ch);
                chk("hit_cnt", hit_cnt, mon_e.cnt);
                chk("aborted", aborted, mon_e.ab);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0;
        ch_bit = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // One frame on channel ch. drop_at<0 means req is held for the whole frame.
    task automatic frame(input int ch, input int len, input logic [15:0] bits,
                         input int drop_at, input int exp_cnt, input bit exp_ab);
        q.push_back('{ch, exp_cnt, exp_ab});
        frame_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
        req[ch] = 1'b1;
        ch_bit[ch] = 1'b0;
        tick;
        if (len == 0) begin
            chk("gnt_len0", gnt, 0);
        end else begin
            chk("gnt_rise", gnt, 1 << ch);
            for (int i = 0; i < len; i++) begin
                ch_bit[ch] = bits[i];
                if (i == drop_at) req[ch] = 1'b0;
                @(negedge clk);
                chk("det_x_scan", det_x, (i == drop_at) ? 0 : bits[i]);
                chk("busy_scan", busy, 1);
                @(posedge clk);
                #1;
                if (i == drop_at) break;
            end
        end
        req[ch] = 1'b0;
        ch_bit[ch] = 1'b0;
        @(negedge clk);
        chk("det_x_report", det_x, 0);
        chk("gnt_report", gnt, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("det_x_idle", det_x, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int rises, last, cyc;
        logic [N_CH-1:0] prev_gnt;

        rst_n = 1'b0;
        req = '0;
        ch_bit = '0;
        frame_len = '0;
        do_reset;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_det_x", det_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_done_ch", done_ch, 0);
        tick;

        // Five ones: hits on bits 4 and 5.
        frame(0, 5, 16'h001F, -1, 2, 1'b0);
        // 1,1,1,0,1,1,1,1: only the second run reaches a 4th one.
        frame(0, 8, 16'h00F7, -1, 1, 1'b0);
        // Zero-length frame reports immediately with no grant.
        frame(1, 0, 16'h0000, -1, 0, 1'b0);
        // Abort after 6 ones: hits on bits 4,5,6.
        frame(2, 10, 16'h03FF, 6, 3, 1'b1);

        // Reset in the middle of a scan: no report, everything idle.
        frame_len[0 +: LEN_W] = 8'd8;
        req[0] = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            ch_bit[0] = 1'b1;
            tick;
        end
        ch_bit[0] = 1'b1;
        rst_n = 1'b0;
        tick;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_det_x", det_x, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hit_cnt", hit_cnt, 0);
        rst_n = 1'b1;
        req = '0;
        ch_bit = '0;
        tick;
        frame(0, 5, 16'h001F, -1, 2, 1'b0);

        // Round robin with all four requesting and length 3 frames.
        do_reset;
        tick;
        for (int c = 0; c < N_CH; c++) frame_len[c*LEN_W +: LEN_W] = 8'd3;
        for (int k = 0; k < 5; k++) q.push_back('{order[k], 0, 1'b0});
        req = 4'b1111;
        rises = 0;
        last = 0;
        cyc = 0;
        prev_gnt = '0;
        while (rises < 5 && cyc < 60) begin
            tick;
            cyc++;
            if (gnt != '0 && prev_gnt == '0) begin
                chk("rr_gnt", gnt, 1 << order[rises]);
                if (rises > 0) chk("rr_period", cyc - last, 5);
                last = cyc;
                rises++;
            end
            prev_gnt = gnt;
        end
        if (rises < 5) begin
            checks++;
            failures++;
            $display("FAIL rr_timeout actual=%0d expected=5", rises);
        end
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (done) break;
        end
        req = '0;
        tick;
        tick;

        // Saturation at 3 for a 2-bit counter. The 12-one frame gives 9 raw
        // hits, so a counter that wraps instead of saturating lands on 1.
        frame(1, 10, 16'h03FF, -1, 3, 1'b0);
        frame(2, 12, 16'h0FFF, -1, 3, 1'b0);

        tick;
        tick;
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
